meas_scan_mux: RTL and testbench

Registered, handshaked successor to the combinational measurement selector. It picks one channel's word from a flat bus of `C_INUM` × `C_IDWIDTH` measurement results. It works either in single-channel mode or by auto-scanning every channel enabled in a mask, and presents each word with its channel index over a valid/ready interface. It sits between the PUF counter/measurement array and the readout/serialiser logic.

---
 rtl/meas_pkg.sv | 21 ++
 rtl/meas_next_ch.sv | 29 ++
 rtl/meas_scan_mux.sv | 127 ++++++++++++
 tb/tb_meas_scan_mux.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared types and helpers for the measurement scan multiplexer.
// Holds the FSM state encoding and a width helper.
package meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/meas_next_ch.sv
// Priority encoder: lowest enabled channel strictly above I_ch,
// or the lowest enabled channel at all when I_first is set.
// Ports: I_mask, I_ch, I_first in; O_ch, O_found out.
module meas_next_ch
    import meas_pkg::*;
#(
    parameter int C_INUM    = 48,
    parameter int C_ISWIDTH = clog2(C_INUM)
) (
    input  logic [C_INUM-1:0]    I_mask,
    input  logic [C_ISWIDTH-1:0] I_ch,
    input  logic                 I_first,
    output logic [C_ISWIDTH-1:0] O_ch,
    output logic                 O_found
);

    // Walk downwards so the lowest qualifying index wins.
    always_comb begin
        O_ch    = '0;
        O_found = 1'b0;
        for (int k = C_INUM - 1; k >= 0; k--) begin
            if (I_mask[k] && (I_first || k > int'(I_ch))) begin
                O_ch    = C_ISWIDTH'(k);
                O_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/meas_scan_mux.sv
// Registered valid/ready channel selector, single-channel or mask scan.
// Ports: I_data/I_start/I_mode/I_sel/I_mask/I_ready in;
// O_data/O_ch/O_valid/O_busy/O_done/O_err out.
module meas_scan_mux
    import meas_pkg::*;
#(
    parameter int C_INUM    = 48,
    parameter int C_IDWIDTH = 24,
    parameter int C_ISWIDTH = clog2(C_INUM)
) (
    input  logic                        I_clk,
    input  logic                        I_rst,
    input  logic [C_INUM*C_IDWIDTH-1:0] I_data,
    input  logic                        I_start,
    input  logic                        I_mode,
    input  logic [C_ISWIDTH-1:0]        I_sel,
    input  logic [C_INUM-1:0]           I_mask,
    output logic [C_IDWIDTH-1:0]        O_data,
    output logic [C_ISWIDTH-1:0]        O_ch,
    output logic                        O_valid,
    input  logic                        I_ready,
    output logic                        O_busy,
    output logic                        O_done,
    output logic                        O_err
);

    state_t                 state;
    logic                   mode_q;
    logic [C_INUM-1:0]      mask_q;
    logic [C_ISWIDTH-1:0]   ch_q;
    logic [C_IDWIDTH-1:0]   cap_word;
    logic [C_INUM-1:0]      srch_mask;
    logic                   srch_first;
    logic [C_ISWIDTH-1:0]   nxt_ch;
    logic                   nxt_found;
    logic                   sel_bad;

    // In IDLE the mask is not latched yet, so search the live input.
    assign srch_first = (state == ST_IDLE);
    assign srch_mask  = srch_first ? I_mask : mask_q;
    assign sel_bad    = (int'(I_sel) >= C_INUM);

    meas_next_ch #(
        .C_INUM    (C_INUM),
        .C_ISWIDTH (C_ISWIDTH)
    ) u_next (
        .I_mask  (srch_mask),
        .I_ch    (ch_q),
        .I_first (srch_first),
        .O_ch    (nxt_ch),
        .O_found (nxt_found)
    );

    always_comb begin
        cap_word = '0;
        for (int k = 0; k < C_INUM; k++) begin
            if (ch_q == C_ISWIDTH'(k)) cap_word = I_data[k*C_IDWIDTH +: C_IDWIDTH];
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state   <= ST_IDLE;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            ch_q    <= '0;
            O_data  <= '0;
            O_ch    <= '0;
            O_valid <= 1'b0;
            O_busy  <= 1'b0;
            O_done  <= 1'b0;
            O_err   <= 1'b0;
        end else begin
            O_done <= 1'b0;
            O_err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (I_start) begin
                        mode_q <= I_mode;
                        mask_q <= I_mask;
                        if (!I_mode) begin
                            if (sel_bad) begin
                                O_err <= 1'b1;
                            end else begin
                                ch_q   <= I_sel;
                                state  <= ST_CAPTURE;
                                O_busy <= 1'b1;
                            end
                        end else if (nxt_found) begin
                            ch_q   <= nxt_ch;
                            state  <= ST_CAPTURE;
                            O_busy <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            O_done <= 1'b1;
                            O_busy <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    O_data  <= cap_word;
                    O_ch    <= ch_q;
                    O_valid <= 1'b1;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (I_ready) begin
                        O_valid <= 1'b0;
                        if (!mode_q || !nxt_found) begin
                            state  <= ST_DONE;
                            O_done <= 1'b1;
                        end else begin
                            ch_q  <= nxt_ch;
                            state <= ST_CAPTURE;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    O_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_scan_mux.sv
// Scoreboard bench for meas_scan_mux: directed runs push expected
// beats, a negedge monitor pops and compares on each handshake.
module tb_meas_scan_mux;

    localparam int NI = 48;
    localparam int DW = 24;
    localparam int SW = 6;

    typedef struct {
        logic [SW-1:0] ch;
        logic [DW-1:0] d;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI*DW-1:0]  I_data;
    logic              I_start;
    logic              I_mode;
    logic [SW-1:0]     I_sel;
    logic [NI-1:0]     I_mask;
    logic [DW-1:0]     O_data;
    logic [SW-1:0]     O_ch;
    logic              O_valid;
    logic              I_ready;
    logic              O_busy;
    logic              O_done;
    logic              O_err;

    logic [DW-1:0]     chw [NI];
    beat_t             exp_q [$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                done_cnt = 0;
    int                err_cnt = 0;

    meas_scan_mux #(
        .C_INUM    (NI),
        .C_IDWIDTH (DW),
        .C_ISWIDTH (SW)
    ) dut (
        .I_clk   (clk),
        .I_rst   (rst),
        .I_data  (I_data),
        .I_start (I_start),
        .I_mode  (I_mode),
        .I_sel   (I_sel),
        .I_mask  (I_mask),
        .O_data  (O_data),
        .O_ch    (O_ch),
        .O_valid (O_valid),
        .I_ready (I_ready),
        .O_busy  (O_busy),
        .O_done  (O_done),
        .O_err   (O_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int k, input logic [7:0] salt);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(k);
        b = 8'hA5 ^ 8'(k * 3);
        return {a, b, salt};
    endfunction

    task automatic fill(input logic [7:0] salt);
        for (int k = 0; k < NI; k++) chw[k] = pat(k, salt);
    endtask

    task automatic pack();
        for (int k = 0; k < NI; k++) I_data[k*DW +: DW] = chw[k];
    endtask

    task automatic push(input int ch);
        beat_t b;
        b.ch = SW'(ch);
        b.d  = chw[ch];
        exp_q.push_back(b);
    endtask

    task automatic kick(input logic m, input logic [SW-1:0] s, input logic [NI-1:0] msk);
        I_mode  = m;
        I_sel   = s;
        I_mask  = msk;
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!O_done && n < budget) begin
            tick();
            n++;
        end
        if (!O_done) chk("done_timeout", 64'(O_done), 64'd1);
    endtask

    task automatic wait_beat(input logic [SW-1:0] ch, input int budget);
        int n;
        n = 0;
        while (!(O_valid && O_ch == ch) && n < budget) begin
            tick();
            n++;
        end
        if (!(O_valid && O_ch == ch)) chk("beat_timeout", 64'(O_ch), 64'(ch));
    endtask

    // Monitor: scoreboard pops, hold stability and bubble checks.
    logic          held = 1'b0;
    logic          prev_hs = 1'b0;
    logic [DW-1:0] hd;
    logic [SW-1:0] hc;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            held    = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) chk("bubble", 64'(O_valid), 64'd0);
            prev_hs = 1'b0;
            if (O_valid) begin
                if (held) begin
                    chk("hold_data", 64'(O_data), 64'(hd));
                    chk("hold_ch", 64'(O_ch), 64'(hc));
                end
                if (I_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_beat: got ch %0d required none", O_ch);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_ch", 64'(O_ch), 64'(e.ch));
                        chk("beat_data", 64'(O_data), 64'(e.d));
                    end
                    held    = 1'b0;
                    prev_hs = 1'b1;
                end else begin
                    held = 1'b1;
                    hd   = O_data;
                    hc   = O_ch;
                end
            end else if (held) begin
                chk("valid_held", 64'(O_valid), 64'd1);
                held = 1'b0;
            end
            if (O_done) done_cnt++;
            if (O_err) err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        logic [NI-1:0] m;

        rst     = 1'b1;
        I_start = 1'b0;
        I_mode  = 1'b0;
        I_sel   = '0;
        I_mask  = '0;
        I_ready = 1'b0;
        I_data  = '0;
        fill(8'h11);
        pack();
        repeat (3) tick();
        chk("rst_data", 64'(O_data), 64'd0);
        chk("rst_ch", 64'(O_ch), 64'd0);
        chk("rst_valid", 64'(O_valid), 64'd0);
        chk("rst_busy", 64'(O_busy), 64'd0);
        chk("rst_done", 64'(O_done), 64'd0);
        chk("rst_err", 64'(O_err), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single channel 5
        chw[5] = 24'hABCDEF;
        pack();
        I_ready = 1'b1;
        d0 = done_cnt;
        push(5);
        kick(1'b0, 6'd5, '0);
        chk("t1_valid_t1", 64'(O_valid), 64'd0);
        chk("t1_busy", 64'(O_busy), 64'd1);
        tick();
        chk("t1_valid_t2", 64'(O_valid), 64'd1);
        chk("t1_ch", 64'(O_ch), 64'd5);
        chk("t1_data", 64'(O_data), 64'hABCDEF);
        tick();
        chk("t1_done", 64'(O_done), 64'd1);
        chk("t1_valid_off", 64'(O_valid), 64'd0);
        tick();
        chk("t1_done_off", 64'(O_done), 64'd0);
        chk("t1_idle", 64'(O_busy), 64'd0);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 2: scan bits 0, 7, 47
        fill(8'h22);
        pack();
        m = '0;
        m[0] = 1'b1;
        m[7] = 1'b1;
        m[47] = 1'b1;
        d0 = done_cnt;
        push(0);
        push(7);
        push(47);
        kick(1'b1, '0, m);
        wait_done(30);
        tick();
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);

        // 3: stall on second beat, data changes while held
        fill(8'h33);
        pack();
        m = '0;
        m[2] = 1'b1;
        m[3] = 1'b1;
        m[9] = 1'b1;
        d0 = done_cnt;
        push(2);
        push(3);
        push(9);
        kick(1'b1, '0, m);
        wait_beat(6'd3, 20);
        I_ready = 1'b0;
        chw[3] = 24'h5A5A5A;
        pack();
        repeat (5) tick();
        chk("t3_still_valid", 64'(O_valid), 64'd1);
        I_ready = 1'b1;
        wait_done(20);
        tick();
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // 4: empty mask, then out-of-range select
        d0 = done_cnt;
        e0 = err_cnt;
        kick(1'b1, '0, '0);
        chk("t4_done", 64'(O_done), 64'd1);
        chk("t4_novalid", 64'(O_valid), 64'd0);
        tick();
        chk("t4_done_off", 64'(O_done), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        kick(1'b0, 6'd50, '0);
        chk("t4_err", 64'(O_err), 64'd1);
        chk("t4_err_busy", 64'(O_busy), 64'd0);
        tick();
        chk("t4_err_off", 64'(O_err), 64'd0);
        chk("t4_err_busy2", 64'(O_busy), 64'd0);
        chk("t4_err_cnt", 64'(err_cnt - e0), 64'd1);

        // 5: start held high and inputs changed mid-run
        fill(8'h55);
        pack();
        m = '0;
        m[1] = 1'b1;
        m[4] = 1'b1;
        m[6] = 1'b1;
        d0 = done_cnt;
        push(1);
        push(4);
        push(6);
        I_mode  = 1'b1;
        I_mask  = m;
        I_start = 1'b1;
        tick();
        I_mode = 1'b0;
        I_sel  = 6'd9;
        I_mask = '0;
        I_mask[2] = 1'b1;
        tick();
        chk("t5_busy", 64'(O_busy), 64'd1);
        wait_done(30);
        I_start = 1'b0;
        tick();
        tick();
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t5_idle", 64'(O_busy), 64'd0);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        // 6: reset while holding a beat, then a fresh run
        fill(8'h66);
        pack();
        I_ready = 1'b0;
        m = '0;
        m[10] = 1'b1;
        m[20] = 1'b1;
        m[30] = 1'b1;
        d0 = done_cnt;
        kick(1'b1, '0, m);
        wait_beat(6'd10, 20);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_data", 64'(O_data), 64'd0);
        chk("t6_ch", 64'(O_ch), 64'd0);
        chk("t6_valid", 64'(O_valid), 64'd0);
        chk("t6_busy", 64'(O_busy), 64'd0);
        chk("t6_done", 64'(O_done), 64'd0);
        chk("t6_err", 64'(O_err), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        I_ready = 1'b1;
        repeat (4) tick();
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_no_valid", 64'(O_valid), 64'd0);
        push(12);
        kick(1'b0, 6'd12, '0);
        tick();
        chk("t6_fresh_valid", 64'(O_valid), 64'd1);
        wait_done(10);
        tick();
        chk("t6_fresh_done", 64'(done_cnt - d0), 64'd1);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
